// File: rtl/touch_pkg.sv
// touch_pkg
//   Shared definitions for the touch gesture path: gesture codes carried from
//   the gesture detector to the CPU-side consumer, the lockout FSM state
//   encoding, and default timing constants (in CLK1K cycles) used by both the
//   detector and the event controller.
package touch_pkg;

  // Gesture codes as presented on EVT_CODE.
  localparam logic [1:0] GEST_NONE   = 2'b00;
  localparam logic [1:0] GEST_SINGLE = 2'b01;
  localparam logic [1:0] GEST_DOUBLE = 2'b10;
  localparam logic [1:0] GEST_LONG   = 2'b11;

  // Lockout FSM states.
  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } lock_state_e;

  // Default timing constants, 1 kHz clock.
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_LOCK_CYC  = 300;
  localparam int DEF_STALE_CYC = 2000;

  // Fixed-priority pick among simultaneous key pulses: long > double > single.
  function automatic logic [1:0] arb_winner(input logic k3, input logic k2, input logic k1);
    if (k3)      return GEST_LONG;
    else if (k2) return GEST_DOUBLE;
    else if (k1) return GEST_SINGLE;
    else         return GEST_NONE;
  endfunction

endpackage

// File: rtl/touch_evt_fifo.sv
// touch_evt_fifo
//   Small synchronous FIFO holding gesture codes.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, din     write request and data; accepted when not full, or when
//                   a pop happens in the same cycle (pop frees the slot first)
//     pop           read request; ignored when empty
//     dout          head entry, forced to zero when empty
//     full, empty   occupancy flags
//     level         occupancy 0..DEPTH
module touch_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible through level_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/touch_event_ctrl.sv
// touch_event_ctrl
//   Collects single/double/long gesture pulses, arbitrates them, queues them
//   in a FIFO and presents them to a consumer over VALID/READY. Applies a
//   lockout after a long press and discards a head entry left unconsumed
//   for STALE_CYC cycles.
//   Ports:
//     CLK1K, RST           1 kHz clock, asynchronous active-high reset
//     EN                   capture enable (queue still drains when low)
//     KEY1/KEY2/KEY3       single / double / long gesture pulses
//     EVT_VALID/EVT_CODE   head entry and its code (00 when empty)
//     EVT_READY            consumer accepts head on VALID & READY
//     LEVEL                queue occupancy
//     OVF                  sticky overflow flag
//     DROP                 one-cycle pulse when any gesture is discarded
//     STALE                one-cycle pulse when the stale timer discards head
//     LOCKED               high during post-long-press lockout
module touch_event_ctrl
  import touch_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOCK_CYC  = DEF_LOCK_CYC,
  parameter int STALE_CYC = DEF_STALE_CYC
) (
  input  logic                   CLK1K,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   KEY1,
  input  logic                   KEY2,
  input  logic                   KEY3,
  output logic                   EVT_VALID,
  output logic [1:0]             EVT_CODE,
  input  logic                   EVT_READY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVF,
  output logic                   DROP,
  output logic                   STALE,
  output logic                   LOCKED
);

  localparam int STALE_W = $clog2(STALE_CYC);
  localparam int LOCK_W  = $clog2(LOCK_CYC);

  lock_state_e        state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
  logic               ovf_q, ovf_d;
  logic               drop_q, drop_d;
  logic               stale_q, stale_d;
  logic               locked_q, locked_d;

  logic [1:0] win_code;
  logic       any_key, losers, capture, user_pop, stale_hit, pop;
  logic       push_req, ovf_hit;
  logic       fifo_full, fifo_empty;

  touch_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (CLK1K),
    .rst   (RST),
    .push  (push_req),
    .pop   (pop),
    .din   (win_code),
    .dout  (EVT_CODE),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  assign EVT_VALID = !fifo_empty;
  assign OVF       = ovf_q;
  assign DROP      = drop_q;
  assign STALE     = stale_q;
  assign LOCKED    = locked_q;

  always_comb begin
    win_code = arb_winner(KEY3, KEY2, KEY1);
    any_key  = KEY1 | KEY2 | KEY3;
    // More than one key asserted means at least one loser.
    losers   = (KEY3 & (KEY2 | KEY1)) | (KEY2 & KEY1);
    capture  = EN && (state_q == ST_OPEN);

    user_pop  = EVT_VALID && EVT_READY;
    // A consumer pop in the same cycle wins over the stale discard.
    stale_hit = EVT_VALID && !user_pop && (stale_cnt_q == STALE_W'(STALE_CYC - 1));
    pop       = user_pop || stale_hit;

    // Push proceeds when full only if a pop frees the slot first.
    push_req = capture && (win_code != GEST_NONE) && (!fifo_full || pop);
    ovf_hit  = capture && (win_code != GEST_NONE) && fifo_full && !pop;

    drop_d  = (EN && !capture && any_key) || (capture && (losers || ovf_hit));
    ovf_d   = ovf_q || ovf_hit;
    stale_d = stale_hit;

    // Age of the current head; restarts whenever the head changes or queue empties.
    if (pop || !EVT_VALID)
      stale_cnt_d = '0;
    else if (stale_cnt_q != '1)
      stale_cnt_d = stale_cnt_q + 1'b1;
    else
      stale_cnt_d = stale_cnt_q;

    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_OPEN: begin
        // A long press counts as accepted whether queued or lost to overflow.
        if (capture && (win_code == GEST_LONG)) begin
          state_d    = ST_LOCK;
          lock_cnt_d = LOCK_W'(LOCK_CYC - 1);
        end
      end
      ST_LOCK: begin
        if (lock_cnt_q == '0) state_d = ST_OPEN;
        else                  lock_cnt_d = lock_cnt_q - 1'b1;
      end
      default: state_d = ST_OPEN;
    endcase
    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge CLK1K or posedge RST) begin
    if (RST) begin
      state_q     <= ST_OPEN;
      lock_cnt_q  <= '0;
      stale_cnt_q <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      stale_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      stale_cnt_q <= stale_cnt_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      stale_q     <= stale_d;
      locked_q    <= locked_d;
    end
  end

endmodule

// File: tb/tb_touch_event_ctrl.sv
module tb_touch_event_ctrl;
  import touch_pkg::*;

  localparam int DEPTH     = 4;
  localparam int LOCK_CYC  = 300;
  localparam int STALE_CYC = 2000;

  logic       CLK1K = 1'b0;
  logic       RST, EN, KEY1, KEY2, KEY3, EVT_READY;
  logic       EVT_VALID;
  logic [1:0] EVT_CODE;
  logic [2:0] LEVEL;
  logic       OVF, DROP, STALE, LOCKED;

  always #5 CLK1K = ~CLK1K;

  touch_event_ctrl #(
    .DEPTH     (DEPTH),
    .LOCK_CYC  (LOCK_CYC),
    .STALE_CYC (STALE_CYC)
  ) dut (
    .CLK1K     (CLK1K),
    .RST       (RST),
    .EN        (EN),
    .KEY1      (KEY1),
    .KEY2      (KEY2),
    .KEY3      (KEY3),
    .EVT_VALID (EVT_VALID),
    .EVT_CODE  (EVT_CODE),
    .EVT_READY (EVT_READY),
    .LEVEL     (LEVEL),
    .OVF       (OVF),
    .DROP      (DROP),
    .STALE     (STALE),
    .LOCKED    (LOCKED)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of gesture codes, remaining locked cycles,
  // cycle index when the current head first became visible.
  logic [1:0] mq[$];
  int         lock_left;
  int         cyc;
  int         head_since;
  bit         m_ovf, m_drop, m_stale;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    lock_left  = 0;
    head_since = 0;
    m_ovf      = 0;
    m_drop     = 0;
    m_stale    = 0;
  endtask

  task automatic check_outputs();
    logic [1:0] exp_code;
    exp_code = GEST_NONE;
    if (mq.size() > 0) exp_code = mq[0];
    check("evt_valid", 32'(EVT_VALID), 32'(mq.size() > 0));
    check("evt_code",  32'(EVT_CODE),  32'(exp_code));
    check("level",     32'(LEVEL),     32'(mq.size()));
    check("ovf",       32'(OVF),       32'(m_ovf));
    check("drop",      32'(DROP),      32'(m_drop));
    check("stale",     32'(STALE),     32'(m_stale));
    check("locked",    32'(LOCKED),    32'(lock_left > 0));
  endtask

  // One clock cycle: drive inputs, check current outputs, advance the model.
  task automatic step(input bit en, input bit k1, input bit k2, input bit k3, input bit rdy);
    bit         was_empty, upop, stl, popped, was_locked, drp;
    logic [1:0] win;
    int         nkeys;
    EN = en; KEY1 = k1; KEY2 = k2; KEY3 = k3; EVT_READY = rdy;
    check_outputs();

    was_empty = (mq.size() == 0);
    upop      = !was_empty && rdy;
    stl       = !was_empty && !upop && ((cyc - head_since) == STALE_CYC - 1);
    popped    = upop || stl;
    if (popped) void'(mq.pop_front());

    was_locked = (lock_left > 0);
    if (was_locked) lock_left--;

    nkeys = int'(k1) + int'(k2) + int'(k3);
    win   = k3 ? GEST_LONG : (k2 ? GEST_DOUBLE : (k1 ? GEST_SINGLE : GEST_NONE));
    drp   = 0;
    if (en && nkeys > 0) begin
      if (was_locked) drp = 1;
      else begin
        if (nkeys > 1) drp = 1;
        if (mq.size() < DEPTH) mq.push_back(win);
        else begin
          drp   = 1;
          m_ovf = 1;
        end
        if (win == GEST_LONG) lock_left = LOCK_CYC;
      end
    end
    if ((popped || was_empty) && mq.size() > 0) head_since = cyc + 1;
    m_drop  = drp;
    m_stale = stl;
    cyc++;
    @(posedge CLK1K);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK1K);
    #1;
    model_reset();
    check_outputs();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; KEY1 = 1'b0; KEY2 = 1'b0; KEY3 = 1'b0; EVT_READY = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge CLK1K);
    #1;

    // Reset state
    $display("step: reset state");
    check_outputs();
    RST = 1'b0;

    // Single tap at cycle 10 with READY high
    $display("step: single tap, ready high");
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    check("tp1_valid", 32'(EVT_VALID), 32'd1);
    check("tp1_code",  32'(EVT_CODE),  32'(GEST_SINGLE));
    step(1, 0, 0, 0, 1);
    check("tp1_level0", 32'(LEVEL), 32'd0);
    step(1, 0, 0, 0, 1);

    // Simultaneous single and double, READY low
    $display("step: single+double arbitration");
    step(1, 1, 1, 0, 0);
    check("tp2_code",  32'(EVT_CODE), 32'(GEST_DOUBLE));
    check("tp2_drop",  32'(DROP),     32'd1);
    check("tp2_level", 32'(LEVEL),    32'd1);
    step(1, 0, 0, 0, 0);
    check("tp2_drop_once", 32'(DROP), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);

    // Full FIFO, push coincides with pop
    $display("step: push with pop while full");
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1);
    check("tp4_level", 32'(LEVEL), 32'd4);
    check("tp4_ovf",   32'(OVF),   32'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);

    // Overflow: five double taps into depth four
    $display("step: overflow");
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
    check("tp3_level", 32'(LEVEL), 32'd4);
    check("tp3_drop",  32'(DROP),  32'd1);
    check("tp3_ovf",   32'(OVF),   32'd1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);

    // Long-press lockout
    $display("step: long-press lockout");
    do_reset();
    step(1, 0, 0, 1, 1);                                   // cycle 0
    check("tp5_locked", 32'(LOCKED), 32'd1);
    for (int i = 1; i < 150; i++) step(1, 0, 0, 0, 1);     // cycles 1..149
    step(1, 1, 0, 0, 1);                                   // cycle 150
    check("tp5_drop",  32'(DROP),  32'd1);
    check("tp5_level", 32'(LEVEL), 32'd0);
    for (int i = 151; i < 301; i++)                        // cycles 151..300
      step((i < 200 || i > 250), (i % 7) == 0, 0, (i % 11) == 0, 1);
    check("tp5_unlocked", 32'(LOCKED), 32'd0);
    step(1, 1, 0, 0, 0);                                   // cycle 301
    check("tp5_queued", 32'(EVT_CODE), 32'(GEST_SINGLE));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);

    // Stale discard
    $display("step: stale discard");
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < STALE_CYC; i++) step(1, 0, 0, 0, 0);
    check("tp6_stale", 32'(STALE),     32'd1);
    check("tp6_valid", 32'(EVT_VALID), 32'd0);
    check("tp6_level", 32'(LEVEL),     32'd0);
    step(1, 0, 0, 0, 0);

    // Asynchronous reset mid-queue
    $display("step: reset mid-queue");
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    #2;
    RST = 1'b1;
    #1;
    check("rst_valid",  32'(EVT_VALID), 32'd0);
    check("rst_code",   32'(EVT_CODE),  32'd0);
    check("rst_level",  32'(LEVEL),     32'd0);
    check("rst_drop",   32'(DROP),      32'd0);
    check("rst_locked", 32'(LOCKED),    32'd0);
    model_reset();
    @(posedge CLK1K);
    #1;
    RST = 1'b0;

    // Randomized traffic against the model
    $display("step: random traffic");
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 90,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 999) < 8,
           $urandom_range(0, 99) < ((i / 1000) % 2 == 0 ? 30 : 2));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/touch_event_ctrl.md
Name: touch_event_ctrl

Overview:
- Sits downstream of the touch gesture detector; collects its single-tap, double-tap and long-press pulses (one CLK1K cycle each).
- Arbitrates simultaneous pulses and buffers gestures in a small FIFO.
- Hands gestures to the CPU-side consumer over a VALID/READY handshake.
- Applies a post-long-press lockout and discards stale, unconsumed gestures.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LOCK_CYC, 300, cycles that new gestures are ignored after a long press is accepted.
- STALE_CYC, 2000, cycles the head entry may wait unconsumed before it is discarded.

Ports:
- CLK1K  in  1  1 kHz system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  capture enable; 0 = ignore all key pulses (FIFO still drains).
- KEY1  in  1  single-tap pulse.
- KEY2  in  1  double-tap pulse.
- KEY3  in  1  long-press pulse.
- EVT_VALID  out  1  head entry available.
- EVT_CODE  out  2  head gesture code: 01 single, 10 double, 11 long; 00 when empty.
- EVT_READY  in  1  consumer accepts head when EVT_VALID & EVT_READY.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy.
- OVF  out  1  sticky; set when an accepted gesture finds the FIFO full; cleared only by RST.
- DROP  out  1  one-cycle pulse: gesture discarded (arbitration loser, lockout, or overflow).
- STALE  out  1  one-cycle pulse: head entry discarded by the stale timer.
- LOCKED  out  1  high during lockout.

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, timers 0, FSM in OPEN.
- Arbitration: priority KEY3 > KEY2 > KEY1; at most one gesture per cycle.
  - Each losing asserted key pulses DROP; DROP is a single bit, so multiple losers give one pulse.
- Capture condition: EN=1 and FSM=OPEN. Otherwise any asserted key is discarded and pulses DROP (no DROP when EN=0).
- Push latency: a gesture captured in cycle N appears at EVT_VALID/EVT_CODE in cycle N+1 if the FIFO was empty. No combinational path from KEYx to outputs.
- FIFO: circular buffer of DEPTH×2 bits. Read/write pointers wrap modulo DEPTH. LEVEL is 0..DEPTH.
- Full with push and no pop: the gesture is dropped, OVF set, DROP pulsed. Existing contents are kept.
- Full with push and pop in the same cycle: pop first, push accepted; LEVEL unchanged; no OVF.
- Empty with push: EVT_VALID rises next cycle; there is no fall-through in the same cycle.
- Pop: on EVT_VALID & EVT_READY, advance the read pointer.
- Stale timer:
  - Counts while EVT_VALID=1 and no pop occurs; clears on pop, on stale discard, and when the FIFO becomes empty.
  - When the count reaches STALE_CYC-1 with no pop that cycle, the head is discarded as a pop and STALE pulses.
  - A pop in that same cycle takes precedence and STALE is not pulsed.
- FSM states:
  - OPEN: capture allowed. An accepted long press (KEY3 written to the FIFO, or dropped for overflow) moves to LOCK and loads the lock counter with LOCK_CYC-1.
  - LOCK: LOCKED=1; all key pulses are discarded with DROP. The counter decrements each cycle; at 0, go to OPEN on the next edge. LOCKED is therefore high for exactly LOCK_CYC cycles.
  - EN deasserted during LOCK does not shorten the lockout.
- Reset mid-operation: immediate async clear; all queued gestures are lost.
- Widths:
  - Stale counter: $clog2(STALE_CYC) bits, saturating.
  - Lock counter: $clog2(LOCK_CYC) bits.
  - No arithmetic wraps except the FIFO pointers.

Decomposition:
- Shared package touch_pkg:
  - gesture code constants GEST_NONE=2'b00, GEST_SINGLE=2'b01, GEST_DOUBLE=2'b10, GEST_LONG=2'b11;
  - FSM state encoding OPEN/LOCK;
  - default timing constants shared with the gesture detector.
- One natural sub-module, touch_evt_fifo: parameterised synchronous FIFO with push, pop, full, empty and level outputs.
- Arbitration, FSM and timers stay in the top level.

Test Plan:
- KEY1 pulse at cycle 10, EVT_READY=1 → EVT_VALID=1 and EVT_CODE=01 at cycle 11 only; LEVEL returns to 0 at cycle 12.
- KEY1 and KEY2 asserted together, READY=0 → one entry with code 10, DROP=1 for one cycle, LEVEL=1.
- Five KEY2 pulses, READY=0, DEPTH=4 → LEVEL=4, fifth pulse gives DROP=1 and OVF=1; draining yields 10,10,10,10.
- With the FIFO full, KEY1 arrives in the same cycle as a pop → LEVEL stays 4, OVF stays 0, new tail code=01.
- KEY3 accepted at cycle 0 → LOCKED high for cycles 1..300; a KEY1 at cycle 150 gives DROP with no entry; a KEY1 at cycle 301 is queued.
- KEY1 queued, READY held 0 → STALE pulses after 2000 cycles of EVT_VALID, then EVT_VALID=0 and LEVEL=0. Assert RST mid-queue → all outputs 0 immediately.
